ga_sync_int: RTL and testbench
==============================

Name: ga_sync_int

Overview:
- Consumer end of the CRTC timing interface. Sits inside the Gate Array and takes the raw HSYNC/VSYNC produced by the CRTC.
- Generates the Z80 raster interrupt from the 52-line counter, with VSYNC resynchronisation.
- Produces the delayed, width-limited monitor syncs.
- Applies screen-mode changes at HSYNC start so that mode switches land on line boundaries.

Parameters:
- INT_LINES, 52: HSYNC falling edges per interrupt.
- VS_HSYNCS, 2: HSYNC falling edges after VSYNC rise before counter resync.
- HS_DELAY, 2: characters from HSYNC_I rise to HSYNC_O rise.
- HS_WIDTH, 4: maximum HSYNC_O width in characters.
- VS_WIDTH, 4: maximum VSYNC_O width in HSYNC_I falling edges.

Ports:
- CLOCK in 1: system clock.
- nRESET in 1: synchronous active-low reset.
- CLKEN in 1: character-clock enable, the same enable that drives the CRTC.
- HSYNC_I in 1: CRTC horizontal sync.
- VSYNC_I in 1: CRTC vertical sync.
- INT_ACK in 1: one-CLOCK pulse on Z80 interrupt acknowledge (M1 & IORQ).
- INT_CLR in 1: one-CLOCK pulse on a Gate Array RMR write with bit 4 set.
- MODE_WR in 1: one-CLOCK pulse on an RMR write.
- MODE_I in 2: mode bits of that write.
- INT_N out 1: active-low Z80 interrupt request.
- HSYNC_O out 1: monitor HSYNC.
- VSYNC_O out 1: monitor VSYNC.
- MODE_O out 2: effective screen mode.
- ICNT out 6: interrupt line counter, for debug/verification.

Behaviour:
- Clocking: reset is nRESET, synchronous, active-low; clock is CLOCK. Everything is rising-edge CLOCK.
- CLKEN gating: sync sampling and counters advance only when CLKEN=1.
- Ungated inputs: INT_ACK, INT_CLR and MODE_WR act on any CLOCK edge.
- Reset values: INT_N=1, HSYNC_O=0, VSYNC_O=0, MODE_O=0, ICNT=0, pending mode=0, all internal counters 0, edge-detect registers 0.
- Edge detect: hs_d and vs_d are the previous CLKEN samples.
  - hs_fall = CLKEN & hs_d & ~HSYNC_I
  - hs_rise = CLKEN & ~hs_d & HSYNC_I
  - vs_rise = CLKEN & ~vs_d & VSYNC_I
- Line counter, on hs_fall:
  - ICNT==INT_LINES-1 → ICNT<=0 and the interrupt is set.
  - Otherwise ICNT<=ICNT+1.
- VSYNC resync:
  - vs_rise loads vsd<=VS_HSYNCS. A vs_rise while vsd!=0 reloads it.
  - On hs_fall with vsd!=0: vsd<=vsd-1.
  - If that decrement reaches 0: ICNT<=0, and the interrupt is set iff the pre-update ICNT>=32.
  - This overrides the normal increment in the same cycle. The interrupt is still set if the increment alone would have set it.
- Interrupt set/clear:
  - Set means INT_N<=0. It stays low until cleared.
  - INT_ACK: INT_N<=1, ICNT[5]<=0.
  - INT_CLR: INT_N<=1, ICNT<=0, vsd unaffected.
- Priority, highest first:
  1. nRESET
  2. INT_CLR
  3. set event in the same cycle
  4. INT_ACK

  Consequence: an ACK coincident with a new set leaves INT_N=0 but still clears ICNT[5] of the post-event value.
- HSYNC_O:
  - hc counts CLKEN cycles while HSYNC_I=1. It resets to 0 on hs_rise and saturates at 15.
  - HSYNC_O=1 iff HSYNC_I=1 and HS_DELAY <= hc < HS_DELAY+HS_WIDTH, registered.
  - A CRTC HSYNC shorter than HS_DELAY+1 characters produces no pulse or a truncated one.
- VSYNC_O:
  - Asserts on the hs_fall where vsd reaches 0.
  - vc counts subsequent hs_fall events.
  - Deasserts when vc==VS_WIDTH or on the first CLKEN sample with VSYNC_I=0, whichever comes first.
- Mode:
  - MODE_WR stores MODE_I into pending.
  - MODE_O<=pending on hs_rise.
  - MODE_WR and hs_rise in the same cycle: MODE_O takes the old pending value; the new value applies at the next HSYNC.
- Reset mid-frame: all state clears; the first hs_fall after reset gives ICNT=1.

Decomposition:
- Shared package (cpc_video_pkg): default constants INT_LINES=52, VS_HSYNCS=2, HS_DELAY=2, HS_WIDTH=4, VS_WIDTH=4, and the 2-bit mode encoding (0:160x200x16, 1:320x4, 2:640x2, 3:160x4).
- One natural sub-module, ga_sync_shaper: the hc/vc counters and HSYNC_O/VSYNC_O generation.
- The interrupt counter and mode latch stay in the top level.

Test Plan:
- Free-running HSYNC every 64 chars, width 14, no VSYNC → INT_N falls on the 52nd hs_fall, ICNT shows 0 then increments; no ACK → INT_N stays low.
- INT_ACK pulse with ICNT=40 → INT_N=1, ICNT=8 on the next CLOCK.
- VSYNC rise with ICNT=30 → two hs_falls later ICNT=0 and INT_N stays 1. Repeat with ICNT=35 → ICNT=0 and INT_N=0.
- Coincidence cases: INT_CLR coincident with the 52nd hs_fall → INT_N=1, ICNT=0. INT_ACK coincident with a set → INT_N=0.
- HSYNC_I width 14 → HSYNC_O high for chars 2..5 after rise (4 chars). Width 4 → HSYNC_O high for chars 2..3 only.
- Mode: MODE_WR(2) mid-line → MODE_O changes exactly at the next hs_rise. VSYNC_I 16 lines wide → VSYNC_O 4 lines wide, starting at the 2nd hs_fall.

Source files
------------

// File: rtl/cpc_video_pkg.sv
`default_nettype none
// ============================================================================
// cpc_video_pkg : shared video timing constants and screen-mode encoding
// Rev 1.0
// ============================================================================
package cpc_video_pkg;

  localparam int c_INT_LINES = 52;
  localparam int c_VS_HSYNCS = 2;
  localparam int c_HS_DELAY  = 2;
  localparam int c_HS_WIDTH  = 4;
  localparam int c_VS_WIDTH  = 4;

  typedef enum logic [1:0] {
    MODE_160X200X16 = 2'd0,
    MODE_320X200X4  = 2'd1,
    MODE_640X200X2  = 2'd2,
    MODE_160X200X4  = 2'd3
  } ga_mode_t;

  // True when character count hc lies in [delay, delay+width).
  function automatic logic hs_in_window(input logic [3:0] hc, input int delay, input int width);
    return (int'(hc) >= delay) && (int'(hc) < delay + width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ga_sync_int_if.sv
`default_nettype none
// ============================================================================
// ga_sync_int_if : CPU-side interrupt acknowledge / RMR write bus
// Rev 1.0
// ============================================================================
interface ga_sync_int_if;
  logic       INT_ACK;
  logic       INT_CLR;
  logic       MODE_WR;
  logic [1:0] MODE_I;
  logic       INT_N;

  modport master (output INT_ACK, INT_CLR, MODE_WR, MODE_I, input INT_N);
  modport slave  (input INT_ACK, INT_CLR, MODE_WR, MODE_I, output INT_N);
endinterface
`default_nettype wire

// File: rtl/ga_sync_shaper.sv
`default_nettype none
// ============================================================================
// ga_sync_shaper : delayed, width-limited monitor HSYNC/VSYNC generation
// Rev 1.0
// ============================================================================
module ga_sync_shaper
  import cpc_video_pkg::*;
#(
  parameter int HS_DELAY = c_HS_DELAY,
  parameter int HS_WIDTH = c_HS_WIDTH,
  parameter int VS_WIDTH = c_VS_WIDTH
) (
  input  wire logic CLOCK,
  input  wire logic nRESET,
  input  wire logic CLKEN,
  input  wire logic HSYNC_I,
  input  wire logic VSYNC_I,
  input  wire logic hs_rise,
  input  wire logic hs_fall,
  input  wire logic vs_start,
  output logic      HSYNC_O,
  output logic      VSYNC_O
);

  localparam int c_VCW = $clog2(VS_WIDTH + 1);

  logic [3:0]       r_hc;
  logic [3:0]       w_hc_next;
  logic [c_VCW-1:0] r_vc;
  logic [c_VCW-1:0] w_vc_inc;
  logic             r_hsync_o;
  logic             r_vsync_o;

  // w_hc_next is the character index of the current sample within HSYNC_I.
  always_comb begin
    w_hc_next = r_hc;
    if (hs_rise)
      w_hc_next = 4'd0;
    else if (HSYNC_I && (r_hc != 4'hF))
      w_hc_next = r_hc + 4'd1;
  end

  assign w_vc_inc = r_vc + c_VCW'(1);

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_hc      <= 4'd0;
      r_vc      <= '0;
      r_hsync_o <= 1'b0;
      r_vsync_o <= 1'b0;
    end else if (CLKEN) begin
      r_hc      <= w_hc_next;
      r_hsync_o <= HSYNC_I & hs_in_window(w_hc_next, HS_DELAY, HS_WIDTH);
      if (vs_start) begin
        r_vsync_o <= 1'b1;
        r_vc      <= '0;
      end else if (r_vsync_o) begin
        if (!VSYNC_I)
          r_vsync_o <= 1'b0;
        else if (hs_fall) begin
          r_vc <= w_vc_inc;
          if (w_vc_inc == c_VCW'(VS_WIDTH))
            r_vsync_o <= 1'b0;
        end
      end
    end
  end

  assign HSYNC_O = r_hsync_o;
  assign VSYNC_O = r_vsync_o;

endmodule
`default_nettype wire

// File: rtl/ga_sync_int.sv
`default_nettype none
// ============================================================================
// ga_sync_int : Gate Array sync consumer - raster interrupt, monitor syncs,
//               line-aligned screen-mode changes
// Rev 1.0
// ============================================================================
module ga_sync_int
  import cpc_video_pkg::*;
#(
  parameter int INT_LINES = c_INT_LINES,
  parameter int VS_HSYNCS = c_VS_HSYNCS,
  parameter int HS_DELAY  = c_HS_DELAY,
  parameter int HS_WIDTH  = c_HS_WIDTH,
  parameter int VS_WIDTH  = c_VS_WIDTH
) (
  input  wire logic    CLOCK,
  input  wire logic    nRESET,
  input  wire logic    CLKEN,
  input  wire logic    HSYNC_I,
  input  wire logic    VSYNC_I,
  ga_sync_int_if.slave bus,
  output logic         HSYNC_O,
  output logic         VSYNC_O,
  output logic [1:0]   MODE_O,
  output logic [5:0]   ICNT
);

  localparam int c_VSDW = $clog2(VS_HSYNCS + 1);

  logic              r_hs_d;
  logic              r_vs_d;
  logic              r_int_n;
  logic [5:0]        r_icnt;
  logic [5:0]        w_icnt_evt;
  logic [5:0]        w_icnt_next;
  logic [c_VSDW-1:0] r_vsd;
  ga_mode_t          r_mode_pend;
  ga_mode_t          r_mode_o;
  logic              w_hs_fall;
  logic              w_hs_rise;
  logic              w_vs_rise;
  logic              w_wrap;
  logic              w_resync;
  logic              w_set;

  assign w_hs_fall = CLKEN &  r_hs_d & ~HSYNC_I;
  assign w_hs_rise = CLKEN & ~r_hs_d &  HSYNC_I;
  assign w_vs_rise = CLKEN & ~r_vs_d &  VSYNC_I;

  // A VSYNC edge reloading the countdown wins over a coincident decrement.
  assign w_wrap   = w_hs_fall & (r_icnt == 6'(INT_LINES - 1));
  assign w_resync = w_hs_fall & ~w_vs_rise & (r_vsd == c_VSDW'(1));
  assign w_set    = w_wrap | (w_resync & (r_icnt >= 6'd32));

  always_comb begin
    w_icnt_evt = r_icnt;
    if (w_resync || w_wrap)
      w_icnt_evt = 6'd0;
    else if (w_hs_fall)
      w_icnt_evt = r_icnt + 6'd1;
    w_icnt_next = w_icnt_evt;
    if (bus.INT_ACK)
      w_icnt_next[5] = 1'b0;
    if (bus.INT_CLR)
      w_icnt_next = 6'd0;
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_int_n     <= 1'b1;
      r_icnt      <= 6'd0;
      r_vsd       <= '0;
      r_mode_pend <= MODE_160X200X16;
      r_mode_o    <= MODE_160X200X16;
    end else begin
      r_icnt <= w_icnt_next;
      if (bus.INT_CLR)
        r_int_n <= 1'b1;
      else if (w_set)
        r_int_n <= 1'b0;
      else if (bus.INT_ACK)
        r_int_n <= 1'b1;
      if (CLKEN) begin
        r_hs_d <= HSYNC_I;
        r_vs_d <= VSYNC_I;
      end
      if (w_vs_rise)
        r_vsd <= c_VSDW'(VS_HSYNCS);
      else if (w_hs_fall && (r_vsd != '0))
        r_vsd <= r_vsd - c_VSDW'(1);
      // Same-cycle write lands in pending only, so the old value is applied here.
      if (w_hs_rise)
        r_mode_o <= r_mode_pend;
      if (bus.MODE_WR)
        r_mode_pend <= ga_mode_t'(bus.MODE_I);
    end
  end

  assign bus.INT_N = r_int_n;
  assign MODE_O    = r_mode_o;
  assign ICNT      = r_icnt;

  ga_sync_shaper #(
    .HS_DELAY (HS_DELAY),
    .HS_WIDTH (HS_WIDTH),
    .VS_WIDTH (VS_WIDTH)
  ) u_shaper (
    .CLOCK    (CLOCK),
    .nRESET   (nRESET),
    .CLKEN    (CLKEN),
    .HSYNC_I  (HSYNC_I),
    .VSYNC_I  (VSYNC_I),
    .hs_rise  (w_hs_rise),
    .hs_fall  (w_hs_fall),
    .vs_start (w_resync),
    .HSYNC_O  (HSYNC_O),
    .VSYNC_O  (VSYNC_O)
  );

endmodule
`default_nettype wire

// File: tb/tb_ga_sync_int.sv
`default_nettype none
// ============================================================================
// tb_ga_sync_int : randomized scenario bench for ga_sync_int with an
//                  event-level reference model
// Rev 1.0
// ============================================================================
module tb_ga_sync_int;

  localparam int INT_LINES = 52;
  localparam int VS_HSYNCS = 2;
  localparam int HS_DELAY  = 2;
  localparam int HS_WIDTH  = 4;
  localparam int VS_WIDTH  = 4;

  logic       CLOCK   = 1'b0;
  logic       nRESET  = 1'b0;
  logic       CLKEN   = 1'b0;
  logic       HSYNC_I = 1'b0;
  logic       VSYNC_I = 1'b0;
  logic       HSYNC_O;
  logic       VSYNC_O;
  logic [1:0] MODE_O;
  logic [5:0] ICNT;

  ga_sync_int_if bus();

  ga_sync_int #(
    .INT_LINES (INT_LINES),
    .VS_HSYNCS (VS_HSYNCS),
    .HS_DELAY  (HS_DELAY),
    .HS_WIDTH  (HS_WIDTH),
    .VS_WIDTH  (VS_WIDTH)
  ) u_dut (
    .CLOCK   (CLOCK),
    .nRESET  (nRESET),
    .CLKEN   (CLKEN),
    .HSYNC_I (HSYNC_I),
    .VSYNC_I (VSYNC_I),
    .bus     (bus),
    .HSYNC_O (HSYNC_O),
    .VSYNC_O (VSYNC_O),
    .MODE_O  (MODE_O),
    .ICNT    (ICNT)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  // Reference model: integer line counting, HSYNCs left before resync, chars into HSYNC.
  int m_icnt, m_vleft, m_pend, m_mode, m_hchars, m_vlines;
  bit m_int_n, m_phs, m_pvs, m_hso, m_vso;

  logic       rec_hso[64];
  bit         rec_mdl_hso[64];
  logic [1:0] rec_mode[64];

  task automatic cycle(input bit en, input bit hs, input bit vs, input bit ack,
                       input bit clr, input bit wr, input logic [1:0] md);
    bit fall, rise, vrise, set, resync;
    int nxt;
    CLKEN = en; HSYNC_I = hs; VSYNC_I = vs;
    bus.INT_ACK = ack; bus.INT_CLR = clr; bus.MODE_WR = wr; bus.MODE_I = md;
    fall = 1'b0; rise = 1'b0; vrise = 1'b0; set = 1'b0; resync = 1'b0;
    if (!nRESET) begin
      m_icnt = 0; m_vleft = 0; m_pend = 0; m_mode = 0; m_hchars = 0; m_vlines = 0;
      m_int_n = 1'b1; m_phs = 1'b0; m_pvs = 1'b0; m_hso = 1'b0; m_vso = 1'b0;
    end else begin
      if (en) begin
        fall  = m_phs && !hs;
        rise  = !m_phs && hs;
        vrise = !m_pvs && vs;
      end
      nxt = m_icnt;
      if (fall) begin
        nxt = (m_icnt + 1) % INT_LINES;
        set = (m_icnt + 1 == INT_LINES);
      end
      if (vrise)
        m_vleft = VS_HSYNCS;
      else if (fall && m_vleft > 0) begin
        m_vleft--;
        if (m_vleft == 0) begin
          resync = 1'b1;
          nxt = 0;
          if (m_icnt >= 32) set = 1'b1;
        end
      end
      if (clr) begin
        m_int_n = 1'b1;
        nxt = 0;
      end else begin
        if (set) m_int_n = 1'b0;
        else if (ack) m_int_n = 1'b1;
        if (ack) nxt = nxt % 32;
      end
      m_icnt = nxt;
      if (en) begin
        if (rise) m_hchars = 0;
        else if (hs) m_hchars++;
        m_hso = hs && (m_hchars >= HS_DELAY) && (m_hchars < HS_DELAY + HS_WIDTH);
        if (resync) begin
          m_vso = 1'b1;
          m_vlines = 0;
        end else if (m_vso) begin
          if (!vs) m_vso = 1'b0;
          else if (fall) begin
            m_vlines++;
            if (m_vlines == VS_WIDTH) m_vso = 1'b0;
          end
        end
        if (rise) m_mode = m_pend;
        m_phs = hs;
        m_pvs = vs;
      end
      if (wr) m_pend = int'(md);
    end
    @(posedge CLOCK);
    @(negedge CLOCK);
    bus.INT_ACK = 1'b0; bus.INT_CLR = 1'b0; bus.MODE_WR = 1'b0;
  endtask

  // One raster line: HSYNC_I high for chars [0,hsw); junk on sync inputs between enables.
  task automatic line(input int len, input int hsw, input bit vs, input int ack_at,
                      input int clr_at, input int wr_at, input logic [1:0] md);
    for (int k = 0; k < len; k++) begin
      int idle;
      idle = int'($urandom_range(0, 1));
      for (int j = 0; j < idle; j++)
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 2'd0);
      cycle(1'b1, k < hsw, vs, k == ack_at, k == clr_at, k == wr_at, md);
      if (k < 64) begin
        rec_hso[k]     = HSYNC_O;
        rec_mdl_hso[k] = m_hso;
        rec_mode[k]    = MODE_O;
      end
    end
  endtask

  task automatic run_lines(input int n);
    for (int i = 0; i < n; i++)
      line(64, 14, 1'b0, -1, -1, -1, 2'd0);
  endtask

  task automatic do_reset(input bit hs_level);
    nRESET = 1'b0;
    for (int i = 0; i < 3; i++)
      cycle(1'($urandom_range(0, 1)), hs_level, 1'b0, 1'($urandom_range(0, 1)), 1'b0,
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++; if (bus.INT_N !== 1'b1) begin bad++; $display("FAIL reset int_n: got %b want 1", bus.INT_N); end
    total++; if (HSYNC_O !== 1'b0) begin bad++; $display("FAIL reset hsync_o: got %b want 0", HSYNC_O); end
    total++; if (VSYNC_O !== 1'b0) begin bad++; $display("FAIL reset vsync_o: got %b want 0", VSYNC_O); end
    total++; if (MODE_O !== 2'd0) begin bad++; $display("FAIL reset mode_o: got %0d want 0", MODE_O); end
    total++; if (ICNT !== 6'd0) begin bad++; $display("FAIL reset icnt: got %0d want 0", ICNT); end
  endtask

  task automatic test_free_run();
    do_reset(1'b0);
    for (int n = 1; n <= 56; n++) begin
      line(64, 14, 1'b0, -1, -1, -1, 2'd0);
      total++; if (ICNT !== 6'(m_icnt)) begin bad++; $display("FAIL free_run icnt line %0d: got %0d want %0d", n, ICNT, m_icnt); end
      total++; if (bus.INT_N !== m_int_n) begin bad++; $display("FAIL free_run int_n line %0d: got %b want %b", n, bus.INT_N, m_int_n); end
      if (n == 1) begin
        total++; if (ICNT !== 6'd1) begin bad++; $display("FAIL free_run first_icnt: got %0d want 1", ICNT); end
      end
      if (n == 51) begin
        total++; if (bus.INT_N !== 1'b1) begin bad++; $display("FAIL free_run int_n_51: got %b want 1", bus.INT_N); end
      end
      if (n == 52) begin
        total++; if (bus.INT_N !== 1'b0) begin bad++; $display("FAIL free_run int_n_52: got %b want 0", bus.INT_N); end
        total++; if (ICNT !== 6'd0) begin bad++; $display("FAIL free_run icnt_52: got %0d want 0", ICNT); end
      end
      if (n == 56) begin
        total++; if (bus.INT_N !== 1'b0) begin bad++; $display("FAIL free_run int_n_held: got %b want 0", bus.INT_N); end
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    total++; if (bus.INT_N !== 1'b1) begin bad++; $display("FAIL free_run ack_int_n: got %b want 1", bus.INT_N); end
    total++; if (ICNT !== 6'd4) begin bad++; $display("FAIL free_run ack_icnt: got %0d want 4", ICNT); end
  endtask

  task automatic test_ack();
    do_reset(1'b0);
    run_lines(40);
    total++; if (ICNT !== 6'd40) begin bad++; $display("FAIL ack pre_icnt: got %0d want 40", ICNT); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    total++; if (ICNT !== 6'd8) begin bad++; $display("FAIL ack icnt: got %0d want 8", ICNT); end
    total++; if (bus.INT_N !== 1'b1) begin bad++; $display("FAIL ack int_n: got %b want 1", bus.INT_N); end
    total++; if (ICNT !== 6'(m_icnt)) begin bad++; $display("FAIL ack model_icnt: got %0d want %0d", ICNT, m_icnt); end
  endtask

  task automatic test_vsync(input int pre, input bit expect_irq);
    do_reset(1'b0);
    run_lines(pre);
    total++; if (ICNT !== 6'(pre)) begin bad++; $display("FAIL vsync pre_icnt: got %0d want %0d", ICNT, pre); end
    for (int k = 1; k <= 19; k++) begin
      bit exp_vs;
      line(64, 14, k <= 16, -1, -1, -1, 2'd0);
      exp_vs = (k >= 2) && (k <= 5);
      total++; if (VSYNC_O !== exp_vs) begin bad++; $display("FAIL vsync vsync_o line %0d: got %b want %b", k, VSYNC_O, exp_vs); end
      total++; if (ICNT !== 6'(m_icnt)) begin bad++; $display("FAIL vsync icnt line %0d: got %0d want %0d", k, ICNT, m_icnt); end
      if (k == 1) begin
        total++; if (ICNT !== 6'(pre + 1)) begin bad++; $display("FAIL vsync icnt_first: got %0d want %0d", ICNT, pre + 1); end
      end
      if (k == 2) begin
        total++; if (ICNT !== 6'd0) begin bad++; $display("FAIL vsync resync_icnt: got %0d want 0", ICNT); end
        total++; if (bus.INT_N !== !expect_irq) begin bad++; $display("FAIL vsync resync_int_n: got %b want %b", bus.INT_N, !expect_irq); end
      end
    end
  endtask

  task automatic test_coincidence();
    do_reset(1'b0);
    run_lines(51);
    total++; if (ICNT !== 6'd51) begin bad++; $display("FAIL coinc pre_icnt: got %0d want 51", ICNT); end
    line(64, 14, 1'b0, -1, 14, -1, 2'd0);
    total++; if (bus.INT_N !== 1'b1) begin bad++; $display("FAIL coinc clr_int_n: got %b want 1", bus.INT_N); end
    total++; if (ICNT !== 6'd0) begin bad++; $display("FAIL coinc clr_icnt: got %0d want 0", ICNT); end
    run_lines(51);
    line(64, 14, 1'b0, 14, -1, -1, 2'd0);
    total++; if (bus.INT_N !== 1'b0) begin bad++; $display("FAIL coinc ack_int_n: got %b want 0", bus.INT_N); end
    total++; if (ICNT !== 6'd0) begin bad++; $display("FAIL coinc ack_icnt: got %0d want 0", ICNT); end
  endtask

  task automatic test_hsync();
    do_reset(1'b0);
    line(64, 14, 1'b0, -1, -1, -1, 2'd0);
    for (int k = 0; k < 16; k++) begin
      bit exp_hs;
      exp_hs = (k >= 2) && (k <= 5);
      total++; if (rec_hso[k] !== exp_hs) begin bad++; $display("FAIL hsync w14 char %0d: got %b want %b", k, rec_hso[k], exp_hs); end
    end
    line(64, 4, 1'b0, -1, -1, -1, 2'd0);
    for (int k = 0; k < 16; k++) begin
      bit exp_hs;
      exp_hs = (k >= 2) && (k <= 3);
      total++; if (rec_hso[k] !== exp_hs) begin bad++; $display("FAIL hsync w4 char %0d: got %b want %b", k, rec_hso[k], exp_hs); end
    end
  endtask

  task automatic test_mode();
    do_reset(1'b0);
    line(64, 14, 1'b0, -1, -1, 30, 2'd2);
    total++; if (rec_mode[63] !== 2'd0) begin bad++; $display("FAIL mode midline: got %0d want 0", rec_mode[63]); end
    line(64, 14, 1'b0, -1, -1, 0, 2'd3);
    total++; if (rec_mode[0] !== 2'd2) begin bad++; $display("FAIL mode at_rise: got %0d want 2", rec_mode[0]); end
    total++; if (rec_mode[63] !== 2'd2) begin bad++; $display("FAIL mode held: got %0d want 2", rec_mode[63]); end
    line(64, 14, 1'b0, -1, -1, -1, 2'd0);
    total++; if (rec_mode[0] !== 2'd3) begin bad++; $display("FAIL mode deferred: got %0d want 3", rec_mode[0]); end
  endtask

  task automatic test_reset_midframe();
    do_reset(1'b0);
    run_lines(10);
    total++; if (ICNT !== 6'd10) begin bad++; $display("FAIL midreset pre_icnt: got %0d want 10", ICNT); end
    nRESET = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    nRESET = 1'b1;
    total++; if (ICNT !== 6'd0) begin bad++; $display("FAIL midreset icnt: got %0d want 0", ICNT); end
    line(64, 14, 1'b0, -1, -1, -1, 2'd0);
    total++; if (ICNT !== 6'd1) begin bad++; $display("FAIL midreset first_fall: got %0d want 1", ICNT); end
  endtask

  task automatic test_random();
    int vs_run;
    vs_run = 0;
    do_reset(1'b0);
    for (int n = 0; n < 200; n++) begin
      int len, hsw, ack_at, clr_at, wr_at;
      bit vs;
      len    = int'($urandom_range(24, 64));
      hsw    = int'($urandom_range(3, 16));
      ack_at = ($urandom_range(0, 3) == 0)  ? int'($urandom_range(0, 63)) % len : -1;
      clr_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63)) % len : -1;
      wr_at  = ($urandom_range(0, 2) == 0)  ? int'($urandom_range(0, 63)) % len : -1;
      if (vs_run == 0 && $urandom_range(0, 19) == 0)
        vs_run = int'($urandom_range(1, 18));
      vs = (vs_run > 0);
      if (vs_run > 0) vs_run--;
      line(len, hsw, vs, ack_at, clr_at, wr_at, 2'($urandom_range(0, 3)));
      total++; if (ICNT !== 6'(m_icnt)) begin bad++; $display("FAIL random icnt line %0d: got %0d want %0d", n, ICNT, m_icnt); end
      total++; if (bus.INT_N !== m_int_n) begin bad++; $display("FAIL random int_n line %0d: got %b want %b", n, bus.INT_N, m_int_n); end
      total++; if (VSYNC_O !== m_vso) begin bad++; $display("FAIL random vsync_o line %0d: got %b want %b", n, VSYNC_O, m_vso); end
      total++; if (MODE_O !== 2'(m_mode)) begin bad++; $display("FAIL random mode_o line %0d: got %0d want %0d", n, MODE_O, m_mode); end
      for (int k = 0; k < len; k++) begin
        total++; if (rec_hso[k] !== rec_mdl_hso[k]) begin bad++; $display("FAIL random hsync_o line %0d char %0d: got %b want %b", n, k, rec_hso[k], rec_mdl_hso[k]); end
      end
    end
  endtask

  initial begin
    bus.INT_ACK = 1'b0;
    bus.INT_CLR = 1'b0;
    bus.MODE_WR = 1'b0;
    bus.MODE_I  = 2'd0;
    @(negedge CLOCK);
    test_reset();
    test_free_run();
    test_ack();
    test_vsync(30, 1'b0);
    test_vsync(35, 1'b1);
    test_coincidence();
    test_hsync();
    test_mode();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
